hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have port CLK, input, 1, pipeline clock; all state updates on the rising edge.
REQ-002 SHALL have port nRST, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have ports rs_id and rt_id, input, 5 each, source registers of the instruction in IF/ID.
REQ-004 SHALL have ports MemRead_idex (input, 1) and dest_idex (input, 5): load flag and destination register of the instruction in ID/EX.
REQ-005 SHALL have ports ihit, dhit, dREN_exmem, dWEN_exmem, input, 1 each; cache hits and data-request flags of EX/MEM.
REQ-006 SHALL have ports branch_taken_exmem, jump_id and halt_memwb, input, 1 each.
REQ-007 SHALL have ports pc_en, ifid_en, idex_en, exmem_en and memwb_en, output, 1 each; register enables.
REQ-008 SHALL have ports ifid_flush, idex_flush and exmem_flush, output, 1 each; synchronous bubble insertion.
REQ-009 SHALL have port halt_out, output, 1, sticky halt.
REQ-010 SHALL have ports stall_cycles and flush_count, output, 16 each; performance counters.

Function
REQ-011 SHALL implement FSM states RUN, DWAIT and HALTED.
REQ-012 In any state, halt_memwb=1 SHALL cause a transition to HALTED; HALTED SHALL be left only by reset.
REQ-013 In HALTED, all enables SHALL be 0, all flushes SHALL be 0, and halt_out SHALL be 1.
REQ-014 Data stall: when (dREN_exmem|dWEN_exmem) && !dhit, all enables SHALL be 0 and all flushes SHALL be 0, in the same cycle (combinational).
REQ-015 In RUN, a data stall SHALL cause a transition to DWAIT.
REQ-016 In DWAIT, dhit=1 SHALL return the FSM to RUN, and that cycle SHALL be evaluated as RUN (pipeline advances).
REQ-017 Branch flush (no data stall): branch_taken_exmem=1 SHALL assert ifid_flush, idex_flush and exmem_flush, with all enables 1.
REQ-018 Load-use (no data stall, no branch): MemRead_idex && dest_idex!=0 && (dest_idex==rs_id || dest_idex==rt_id) SHALL assert pc_en=0, ifid_en=0 and idex_flush=1, with exmem_en=1 and memwb_en=1.
REQ-019 Jump (none of the above): jump_id=1 SHALL assert ifid_flush=1 with all enables 1.
REQ-020 Fetch wait (none of the above): ihit=0 SHALL assert pc_en=0 and ifid_flush=1, with the other enables 1.
REQ-021 Priority SHALL be halt > data stall > branch > load-use > jump > fetch wait.
REQ-022 A branch coincident with a data stall SHALL be deferred, frozen in EX/MEM, and applied in the cycle dhit arrives.
REQ-023 Otherwise, all enables SHALL be 1 and all flushes SHALL be 0.
REQ-024 stall_cycles SHALL increment when pc_en=0 and state!=HALTED, saturating at 16'hFFFF.
REQ-025 flush_count SHALL increment on each cycle REQ-017 applies, saturating at 16'hFFFF.
REQ-026 Register 0 SHALL never trigger a load-use stall.

Reset
REQ-027 nRST low SHALL set the state to RUN, stall_cycles and flush_count to 0, and halt_out to 0, immediately (asynchronously).
REQ-028 Reset asserted mid-DWAIT or mid-HALTED SHALL abandon that state with no residual stall.
REQ-029 During reset, combinational outputs SHALL decode as RUN from the current inputs.

Structure
REQ-030 The hazard_state_t enum SHALL be added to cpu_types_pkg; 5-bit register types SHALL use the existing package regbits_t.
REQ-031 The counter SHALL be a sub-module sat_counter (16-bit, enable, async active-low reset), instantiated twice.
REQ-032 An interface hazard_unit_if SHALL carry all non-clock/reset ports.

Verification
REQ-033 Load lw $3 in ID/EX with rs_id=3 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cycles increments to 1.
REQ-034 dREN_exmem=1, dhit=0 for 4 cycles, then dhit=1 -> enables 0 for 4 cycles, state DWAIT, stall_cycles=4; on the fifth cycle, enables 1 and state RUN.
REQ-035 branch_taken_exmem=1 together with a data miss for 2 cycles -> no flush while stalled; on the dhit cycle, all three flushes 1 and flush_count=1.
REQ-036 halt_memwb pulse for 1 cycle -> halt_out=1 and all enables 0 indefinitely; nRST low -> halt_out=0 and counters 0.
REQ-037 MemRead_idex=1, dest_idex=0, rs_id=0 -> no stall; ihit=0 alone -> pc_en=0, ifid_flush=1, idex_en=1.
REQ-038 Force stall_cycles to 16'hFFFE, then stall 3 cycles -> stall_cycles holds 16'hFFFF.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register indices and the hazard unit FSM encoding.
package cpu_types_pkg;
    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } hazard_state_t;

    localparam int PERF_W = 16;
endpackage

// File: rtl/hazard_unit_if.sv
// Bundle of every hazard unit signal except clock and reset, with views for both sides.
interface hazard_unit_if;
    import cpu_types_pkg::*;

    regbits_t             rs_id, rt_id, dest_idex;
    logic                 MemRead_idex;
    logic                 ihit, dhit, dREN_exmem, dWEN_exmem;
    logic                 branch_taken_exmem, jump_id, halt_memwb;
    logic                 pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic                 ifid_flush, idex_flush, exmem_flush;
    logic                 halt_out;
    logic [PERF_W-1:0]    stall_cycles, flush_count;

    modport hu (
        input  rs_id, rt_id, dest_idex, MemRead_idex, ihit, dhit, dREN_exmem, dWEN_exmem,
               branch_taken_exmem, jump_id, halt_memwb,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               exmem_flush, halt_out, stall_cycles, flush_count
    );

    modport dp (
        output rs_id, rt_id, dest_idex, MemRead_idex, ihit, dhit, dREN_exmem, dWEN_exmem,
               branch_taken_exmem, jump_id, halt_memwb,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               exmem_flush, halt_out, stall_cycles, flush_count
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         gclk,
    input  logic         grst_n,
    input  logic         en,
    output logic [W-1:0] count
);
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n)
            count <= '0;
        else if (en && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end
endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: stall/flush decode by fixed priority, halt FSM, perf counters.
module hazard_unit
    import cpu_types_pkg::*;
(
    input  logic              CLK,
    input  logic              nRST,
    input  regbits_t          rs_id,
    input  regbits_t          rt_id,
    input  logic              MemRead_idex,
    input  regbits_t          dest_idex,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              dREN_exmem,
    input  logic              dWEN_exmem,
    input  logic              branch_taken_exmem,
    input  logic              jump_id,
    input  logic              halt_memwb,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              halt_out,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_count
);
    hazard_state_t state;
    logic dstall, load_use, halted, branch_apply;

    assign dstall   = (dREN_exmem | dWEN_exmem) & ~dhit;
    assign load_use = MemRead_idex && (dest_idex != '0) &&
                      ((dest_idex == rs_id) || (dest_idex == rt_id));
    assign halted   = (state == HALTED) | halt_memwb;
    // A branch seen during a data miss stays frozen in EX/MEM and fires here once dhit arrives.
    assign branch_apply = ~halted & ~dstall & branch_taken_exmem;

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (halted || dstall) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (branch_taken_exmem) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (jump_id) begin
            ifid_flush = 1'b1;
        end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= RUN;
            halt_out <= 1'b0;
        end else if (halt_memwb) begin
            state    <= HALTED;
            halt_out <= 1'b1;
        end else begin
            case (state)
                RUN:     if (dstall) state <= DWAIT;
                DWAIT:   if (!dstall) state <= RUN;
                HALTED:  state <= HALTED;
                default: state <= RUN;
            endcase
        end
    end

    sat_counter #(.W(PERF_W)) u_stall_cnt (
        .gclk   (CLK),
        .grst_n (nRST),
        .en     (~pc_en && (state != HALTED)),
        .count  (stall_cycles)
    );

    sat_counter #(.W(PERF_W)) u_flush_cnt (
        .gclk   (CLK),
        .grst_n (nRST),
        .en     (branch_apply),
        .count  (flush_count)
    );
endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit; expectations queued by the driver, checked by a monitor.
module tb_hazard_unit;
    import cpu_types_pkg::*;

    logic CLK, nRST;
    regbits_t rs_id, rt_id, dest_idex;
    logic MemRead_idex, ihit, dhit, dREN_exmem, dWEN_exmem;
    logic branch_taken_exmem, jump_id, halt_memwb;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, halt_out;
    logic [15:0] stall_cycles, flush_count;

    hazard_unit dut (
        .CLK(CLK), .nRST(nRST), .rs_id(rs_id), .rt_id(rt_id),
        .MemRead_idex(MemRead_idex), .dest_idex(dest_idex),
        .ihit(ihit), .dhit(dhit), .dREN_exmem(dREN_exmem), .dWEN_exmem(dWEN_exmem),
        .branch_taken_exmem(branch_taken_exmem), .jump_id(jump_id), .halt_memwb(halt_memwb),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .halt_out(halt_out),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush}
    localparam logic [7:0] C_RUN = 8'b11111_000;
    localparam logic [7:0] C_STL = 8'b00000_000;
    localparam logic [7:0] C_BR  = 8'b11111_111;
    localparam logic [7:0] C_LU  = 8'b00111_010;
    localparam logic [7:0] C_JMP = 8'b11111_100;
    localparam logic [7:0] C_FW  = 8'b01111_100;

    typedef struct {
        string      nm;
        logic [7:0] ctl;
        logic       h;
        int         sc;  // negative: not checked
        int         fc;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int checks = 0;
    int failures = 0;

    always @(negedge CLK) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            checks++;
            if ({pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush} !== me.ctl) begin
                failures++;
                $display("FAIL %s ctl got %b want %b", me.nm,
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush}, me.ctl);
            end
            checks++;
            if (halt_out !== me.h) begin
                failures++;
                $display("FAIL %s halt_out got %b want %b", me.nm, halt_out, me.h);
            end
            if (me.sc >= 0) begin
                checks++;
                if (stall_cycles !== 16'(me.sc)) begin
                    failures++;
                    $display("FAIL %s stall_cycles got %0d want %0d", me.nm, stall_cycles, me.sc);
                end
            end
            if (me.fc >= 0) begin
                checks++;
                if (flush_count !== 16'(me.fc)) begin
                    failures++;
                    $display("FAIL %s flush_count got %0d want %0d", me.nm, flush_count, me.fc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic idle();
        rs_id = 5'd0; rt_id = 5'd0; dest_idex = 5'd0; MemRead_idex = 1'b0;
        ihit = 1'b1; dhit = 1'b0; dREN_exmem = 1'b0; dWEN_exmem = 1'b0;
        branch_taken_exmem = 1'b0; jump_id = 1'b0; halt_memwb = 1'b0;
    endtask

    // Inputs are already applied; expectation describes the cycle up to the next rising edge.
    task automatic cyc(input string nm, input logic [7:0] ctl, input logic h, input int sc, input int fc);
        exp_t e;
        e.nm = nm; e.ctl = ctl; e.h = h; e.sc = sc; e.fc = fc;
        q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle();
        nRST = 1'b0;
        @(posedge CLK);
        #1;
        cyc("rst_idle", C_RUN, 0, 0, 0);
        ihit = 1'b0;
        cyc("rst_decode_fw", C_FW, 0, 0, 0);
        idle(); nRST = 1'b1;
        cyc("run_idle", C_RUN, 0, 0, 0);

        MemRead_idex = 1'b1; dest_idex = 5'd3; rs_id = 5'd3;
        cyc("lu_rs", C_LU, 0, 0, 0);
        idle();
        cyc("lu_rs_after", C_RUN, 0, 1, 0);
        MemRead_idex = 1'b1; dest_idex = 5'd5; rs_id = 5'd2; rt_id = 5'd5;
        cyc("lu_rt", C_LU, 0, 1, 0);
        idle();
        cyc("lu_rt_after", C_RUN, 0, 2, 0);

        MemRead_idex = 1'b1; dest_idex = 5'd0; rs_id = 5'd0; rt_id = 5'd0;
        cyc("lu_r0", C_RUN, 0, 2, 0);
        idle(); ihit = 1'b0;
        cyc("fetch_wait", C_FW, 0, 2, 0);
        idle(); jump_id = 1'b1;
        cyc("jump", C_JMP, 0, 3, 0);
        MemRead_idex = 1'b1; dest_idex = 5'd4; rs_id = 5'd4;
        cyc("lu_over_jump", C_LU, 0, 3, 0);
        idle();
        cyc("after_jump", C_RUN, 0, 4, 0);

        dREN_exmem = 1'b1;
        for (int i = 0; i < 4; i++) cyc("dmiss", C_STL, 0, 4 + i, 0);
        dhit = 1'b1;
        cyc("dhit_release", C_RUN, 0, 8, 0);
        idle();
        cyc("after_dhit", C_RUN, 0, 8, 0);

        branch_taken_exmem = 1'b1; dWEN_exmem = 1'b1;
        cyc("br_dmiss0", C_STL, 0, 8, 0);
        cyc("br_dmiss1", C_STL, 0, 9, 0);
        dhit = 1'b1;
        cyc("br_dhit", C_BR, 0, 10, 0);
        idle();
        cyc("br_after", C_RUN, 0, 10, 1);
        branch_taken_exmem = 1'b1; MemRead_idex = 1'b1; dest_idex = 5'd7; rt_id = 5'd7;
        cyc("br_over_lu", C_BR, 0, 10, 1);
        idle();
        cyc("br2_after", C_RUN, 0, 10, 2);

        force dut.u_stall_cnt.count = 16'hFFFE;
        #1;
        release dut.u_stall_cnt.count;
        ihit = 1'b0;
        cyc("sat0", C_FW, 0, 16'hFFFE, 2);
        cyc("sat1", C_FW, 0, 16'hFFFF, 2);
        cyc("sat2", C_FW, 0, 16'hFFFF, 2);
        idle();
        cyc("sat_hold", C_RUN, 0, 16'hFFFF, 2);

        halt_memwb = 1'b1;
        cyc("halt_pulse", C_STL, 0, -1, 2);
        idle();
        cyc("halted0", C_STL, 1, 16'hFFFF, 2);
        branch_taken_exmem = 1'b1; ihit = 1'b0;
        cyc("halted_br", C_STL, 1, 16'hFFFF, 2);
        idle();
        cyc("halted2", C_STL, 1, 16'hFFFF, 2);
        nRST = 1'b0;
        cyc("halt_rst", C_RUN, 0, 0, 0);
        nRST = 1'b1;
        cyc("post_halt_rst", C_RUN, 0, 0, 0);

        dREN_exmem = 1'b1;
        cyc("dw_rst0", C_STL, 0, 0, 0);
        cyc("dw_rst1", C_STL, 0, 1, 0);
        idle(); nRST = 1'b0;
        cyc("dw_rst", C_RUN, 0, 0, 0);
        nRST = 1'b1;
        cyc("dw_post_rst", C_RUN, 0, 0, 0);

        @(negedge CLK);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got %0d want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
